// File: rtl/debug_controller.sv
// Debug controller for the pipelined MIPS core: UART command decode, program load,
// run/step/breakpoint control and a back-pressured state dump into the TX FIFO.
module debug_controller #(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LATCH_WORDS  = 11,
    parameter int MEM_ADDR_W   = 8,
    parameter int IMEM_WORDS   = 256,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_data_ready,
    input  logic [31:0]                 i_data,
    input  logic                        i_program_end,
    input  logic [31:0]                 i_pc,
    input  logic [LATCH_WORDS*32-1:0]   i_latches,
    input  logic [31:0]                 i_register_content,
    input  logic [31:0]                 i_mem_data_content,
    input  logic                        i_fifo_full,
    output logic                        o_halt,
    output logic                        o_pc_reset,
    output logic                        o_stall,
    output logic                        o_write_instruction_flag,
    output logic [31:0]                 o_instruction_to_write,
    output logic [31:0]                 o_address_to_write_inst,
    output logic [REG_ADDR_W-1:0]       o_reg_addr_to_read,
    output logic [31:0]                 o_addr_to_read_mem_data,
    output logic [31:0]                 o_data_to_fifo,
    output logic                        o_write_en_fifo,
    output logic                        o_busy
);

    localparam logic [31:0] CMD_LOAD  = 32'h006c6f6d;
    localparam logic [31:0] CMD_CONT  = 32'h00636f6d;
    localparam logic [31:0] CMD_STEP  = 32'h0073746d;
    localparam logic [31:0] CMD_BP    = 32'h0062706d;
    localparam logic [31:0] CMD_NEXT  = 32'h6e787374;
    localparam logic [31:0] CMD_CANCEL = 32'h636c7374;
    localparam logic [31:0] WORD_ENDD = 32'h656e6464;
    localparam logic [31:0] LOAD_TERM = 32'hFFFFFFFF;

    localparam int MEM_WORDS = (2 ** MEM_ADDR_W) / 4;
    localparam int MEM_CNT_W = $clog2(MEM_WORDS + 1);
    localparam int LAT_CNT_W = $clog2(LATCH_WORDS + 1);
    localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 2);

    localparam logic [REG_ADDR_W:0] REG_END   = (REG_ADDR_W + 1)'(NUM_REGS);
    localparam logic [REG_ADDR_W:0] REG_ONE   = (REG_ADDR_W + 1)'(1);
    localparam logic [LAT_CNT_W-1:0] LAT_END  = LAT_CNT_W'(LATCH_WORDS);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);
    localparam logic [MEM_CNT_W-1:0] MEM_END  = MEM_CNT_W'(MEM_WORDS);
    localparam logic [MEM_CNT_W-1:0] MEM_ONE  = MEM_CNT_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_END  = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [31:0] IMEM_LAST_ADDR    = 32'((IMEM_WORDS - 1) * 4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BP_ADDR,
        ST_RUN,
        ST_PAUSED,
        ST_STEP,
        ST_DUMP
    } state_t;

    typedef enum logic [2:0] {
        PH_REGS,
        PH_LATCH,
        PH_MEM_DATA,
        PH_MEM_ADDR,
        PH_END,
        PH_DONE
    } phase_t;

    state_t                 state_reg;
    phase_t                 phase_reg;
    logic                   prog_ready_reg;
    logic                   armed_reg;
    logic                   draining_reg;
    logic                   return_idle_reg;
    logic                   load_done_reg;
    logic [31:0]            bp_addr_reg;
    logic [DRAIN_W-1:0]     drain_cnt_reg;
    logic [REG_ADDR_W:0]    reg_cnt_reg;
    logic [LAT_CNT_W-1:0]   lat_cnt_reg;
    logic [MEM_CNT_W-1:0]   mem_cnt_reg;
    logic                   out_valid_reg;
    logic [31:0]            out_data_reg;
    logic                   halt_reg;
    logic                   pc_reset_reg;
    logic                   stall_reg;
    logic                   wr_inst_reg;
    logic [31:0]            inst_reg;
    logic [31:0]            inst_addr_reg;

    logic [31:0]            latch_words [LATCH_WORDS];
    logic                   slot_free;
    logic                   push;
    logic                   mem_word_ok;
    logic [DRAIN_W-1:0]     drain_next;

    generate
        for (genvar gi = 0; gi < LATCH_WORDS; gi++) begin : g_latch_unpack
            assign latch_words[gi] = i_latches[32*gi +: 32];
        end
    endgenerate

    // The output word register doubles as a one-entry skid: it holds its word
    // while the FIFO is full and is refilled in the same cycle it is pushed.
    assign push        = out_valid_reg && !i_fifo_full;
    assign slot_free   = !out_valid_reg || !i_fifo_full;
    assign mem_word_ok = (i_mem_data_content != 32'd0) && !$isunknown(i_mem_data_content);
    assign drain_next  = drain_cnt_reg + DRAIN_ONE;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= ST_IDLE;
            phase_reg       <= PH_REGS;
            prog_ready_reg  <= 1'b0;
            armed_reg       <= 1'b0;
            draining_reg    <= 1'b0;
            return_idle_reg <= 1'b0;
            load_done_reg   <= 1'b0;
            bp_addr_reg     <= 32'd0;
            drain_cnt_reg   <= '0;
            reg_cnt_reg     <= '0;
            lat_cnt_reg     <= '0;
            mem_cnt_reg     <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= 32'd0;
            halt_reg        <= 1'b1;
            pc_reset_reg    <= 1'b0;
            stall_reg       <= 1'b0;
            wr_inst_reg     <= 1'b0;
            inst_reg        <= 32'd0;
            inst_addr_reg   <= 32'd0;
        end else begin
            pc_reset_reg <= 1'b0;
            wr_inst_reg  <= 1'b0;
            if (push) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_data_ready) begin
                        if (i_data == CMD_LOAD) begin
                            prog_ready_reg <= 1'b0;
                            state_reg      <= ST_LOAD;
                        end else if (prog_ready_reg) begin
                            if (i_data == CMD_CONT) begin
                                halt_reg  <= 1'b0;
                                armed_reg <= 1'b0;
                                state_reg <= ST_RUN;
                            end else if (i_data == CMD_STEP) begin
                                state_reg <= ST_PAUSED;
                            end else if (i_data == CMD_BP) begin
                                state_reg <= ST_BP_ADDR;
                            end
                        end
                    end
                end

                // A word is only taken once the previous write has retired and the
                // address has moved on; UART words arrive far slower than that.
                ST_LOAD: begin
                    if (wr_inst_reg) begin
                        if (load_done_reg) begin
                            inst_addr_reg  <= 32'd0;
                            prog_ready_reg <= 1'b1;
                            pc_reset_reg   <= 1'b1;
                            load_done_reg  <= 1'b0;
                            state_reg      <= ST_IDLE;
                        end else begin
                            inst_addr_reg <= inst_addr_reg + 32'd4;
                        end
                    end else if (i_data_ready) begin
                        inst_reg      <= i_data;
                        wr_inst_reg   <= 1'b1;
                        load_done_reg <= (i_data == LOAD_TERM) || (inst_addr_reg == IMEM_LAST_ADDR);
                    end
                end

                ST_BP_ADDR: begin
                    if (i_data_ready) begin
                        bp_addr_reg <= i_data;
                        armed_reg   <= 1'b1;
                        halt_reg    <= 1'b0;
                        state_reg   <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (armed_reg && (i_pc == bp_addr_reg)) begin
                        halt_reg        <= 1'b1;
                        armed_reg       <= 1'b0;
                        return_idle_reg <= 1'b0;
                        state_reg       <= ST_DUMP;
                    end else if (draining_reg) begin
                        drain_cnt_reg <= drain_next;
                        if (drain_next >= DRAIN_END) begin
                            halt_reg        <= 1'b1;
                            return_idle_reg <= 1'b1;
                            state_reg       <= ST_DUMP;
                        end
                    end else if (i_program_end) begin
                        stall_reg     <= 1'b1;
                        draining_reg  <= 1'b1;
                        drain_cnt_reg <= '0;
                    end
                end

                ST_PAUSED: begin
                    stall_reg <= i_program_end;
                    if (i_data_ready) begin
                        if (i_data == CMD_NEXT) begin
                            halt_reg  <= 1'b0;
                            state_reg <= ST_STEP;
                        end else if (i_data == CMD_CANCEL) begin
                            pc_reset_reg <= 1'b1;
                            armed_reg    <= 1'b0;
                            stall_reg    <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else if (i_data == CMD_CONT) begin
                            halt_reg  <= 1'b0;
                            armed_reg <= 1'b0;
                            stall_reg <= 1'b0;
                            state_reg <= ST_RUN;
                        end
                    end
                end

                // The pipeline ran for exactly one cycle; freeze it and dump.
                ST_STEP: begin
                    stall_reg       <= i_program_end;
                    halt_reg        <= 1'b1;
                    return_idle_reg <= 1'b0;
                    state_reg       <= ST_DUMP;
                end

                ST_DUMP: begin
                    case (phase_reg)
                        PH_REGS: begin
                            if (reg_cnt_reg == REG_END) begin
                                phase_reg <= PH_LATCH;
                            end else if (slot_free) begin
                                out_data_reg  <= i_register_content;
                                out_valid_reg <= 1'b1;
                                reg_cnt_reg   <= reg_cnt_reg + REG_ONE;
                            end
                        end
                        PH_LATCH: begin
                            if (lat_cnt_reg == LAT_END) begin
                                phase_reg <= PH_MEM_DATA;
                            end else if (slot_free) begin
                                out_data_reg  <= latch_words[lat_cnt_reg];
                                out_valid_reg <= 1'b1;
                                lat_cnt_reg   <= lat_cnt_reg + LAT_ONE;
                            end
                        end
                        PH_MEM_DATA: begin
                            if (mem_cnt_reg == MEM_END) begin
                                phase_reg <= PH_END;
                            end else if (!mem_word_ok) begin
                                mem_cnt_reg <= mem_cnt_reg + MEM_ONE;
                            end else if (slot_free) begin
                                out_data_reg  <= i_mem_data_content;
                                out_valid_reg <= 1'b1;
                                phase_reg     <= PH_MEM_ADDR;
                            end
                        end
                        PH_MEM_ADDR: begin
                            if (slot_free) begin
                                out_data_reg  <= o_addr_to_read_mem_data;
                                out_valid_reg <= 1'b1;
                                mem_cnt_reg   <= mem_cnt_reg + MEM_ONE;
                                phase_reg     <= PH_MEM_DATA;
                            end
                        end
                        PH_END: begin
                            if (slot_free) begin
                                out_data_reg  <= WORD_ENDD;
                                out_valid_reg <= 1'b1;
                                phase_reg     <= PH_DONE;
                            end
                        end
                        PH_DONE: begin
                            // Leave only once the marker word has actually been pushed.
                            if (slot_free) begin
                                phase_reg   <= PH_REGS;
                                reg_cnt_reg <= '0;
                                lat_cnt_reg <= '0;
                                mem_cnt_reg <= '0;
                                if (return_idle_reg) begin
                                    pc_reset_reg  <= 1'b1;
                                    draining_reg  <= 1'b0;
                                    drain_cnt_reg <= '0;
                                    stall_reg     <= 1'b0;
                                    state_reg     <= ST_IDLE;
                                end else begin
                                    state_reg <= ST_PAUSED;
                                end
                            end
                        end
                        default: phase_reg <= PH_REGS;
                    endcase
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_halt                   = halt_reg;
    assign o_pc_reset               = pc_reset_reg;
    assign o_stall                  = stall_reg;
    assign o_write_instruction_flag = wr_inst_reg;
    assign o_instruction_to_write   = inst_reg;
    assign o_address_to_write_inst  = inst_addr_reg;
    assign o_reg_addr_to_read       = reg_cnt_reg[REG_ADDR_W-1:0];
    assign o_addr_to_read_mem_data  = {{(32 - MEM_CNT_W - 2){1'b0}}, mem_cnt_reg, 2'b00};
    assign o_data_to_fifo           = out_data_reg;
    assign o_write_en_fifo          = push;
    assign o_busy                   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: FIFO and instruction-write scoreboards built
// from the dump/load rules, plus hand-timed checks on halt, stall and PC reset.
`timescale 1ns/1ps
module tb_debug_controller;

    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int LATCH_WORDS  = 11;
    localparam int MEM_ADDR_W   = 8;
    localparam int IMEM_WORDS   = 256;
    localparam int DRAIN_CYCLES = 3;
    localparam int MEM_WORDS    = (2 ** MEM_ADDR_W) / 4;

    localparam logic [31:0] CMD_LOAD   = 32'h006c6f6d;
    localparam logic [31:0] CMD_CONT   = 32'h00636f6d;
    localparam logic [31:0] CMD_STEP   = 32'h0073746d;
    localparam logic [31:0] CMD_BP     = 32'h0062706d;
    localparam logic [31:0] CMD_NEXT   = 32'h6e787374;
    localparam logic [31:0] CMD_CANCEL = 32'h636c7374;
    localparam logic [31:0] WORD_ENDD  = 32'h656e6464;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      data_ready;
    logic [31:0]               data;
    logic                      program_end;
    logic [31:0]               pc;
    logic [LATCH_WORDS*32-1:0] latches;
    logic [31:0]               reg_content;
    logic [31:0]               mem_content;
    logic                      fifo_full;
    logic                      halt, pc_reset, stall, wr_flag, wen, busy;
    logic [31:0]               inst, inst_addr, mem_addr, fifo_data;
    logic [REG_ADDR_W-1:0]     reg_addr;

    logic [31:0] mem_model [MEM_WORDS];
    logic [31:0] exp_fifo [$];
    logic [31:0] exp_wr_addr [$];
    logic [31:0] exp_wr_data [$];
    int checks = 0;
    int errors = 0;
    int push_count = 0;
    int pcr_count = 0;

    always #5 clk = ~clk;

    debug_controller #(
        .NUM_REGS(NUM_REGS), .REG_ADDR_W(REG_ADDR_W), .LATCH_WORDS(LATCH_WORDS),
        .MEM_ADDR_W(MEM_ADDR_W), .IMEM_WORDS(IMEM_WORDS), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_data_ready(data_ready), .i_data(data),
        .i_program_end(program_end), .i_pc(pc), .i_latches(latches),
        .i_register_content(reg_content), .i_mem_data_content(mem_content),
        .i_fifo_full(fifo_full), .o_halt(halt), .o_pc_reset(pc_reset), .o_stall(stall),
        .o_write_instruction_flag(wr_flag), .o_instruction_to_write(inst),
        .o_address_to_write_inst(inst_addr), .o_reg_addr_to_read(reg_addr),
        .o_addr_to_read_mem_data(mem_addr), .o_data_to_fifo(fifo_data),
        .o_write_en_fifo(wen), .o_busy(busy)
    );

    function automatic logic [31:0] reg_value(input int idx);
        return 32'h1000_0000 + 32'(idx) * 32'h11;
    endfunction

    function automatic logic [31:0] latch_value(input int k);
        return 32'hCAFE_0000 + 32'(k);
    endfunction

    always_comb reg_content = reg_value(int'(reg_addr));

    always_comb begin
        mem_content = 32'd0;
        if (mem_addr < 32'(4 * MEM_WORDS)) mem_content = mem_model[mem_addr[MEM_ADDR_W-1:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboards: every FIFO push and every instruction write is matched in order.
    always @(negedge clk) begin
        if (pc_reset) pcr_count++;
        if (wen) begin
            push_count++;
            if (fifo_full) begin
                checks++; errors++;
                $display("FAIL push_while_full: got push of %h expected none", fifo_data);
            end else if (exp_fifo.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_push: got %h expected no push", fifo_data);
            end else begin
                check("fifo_push", fifo_data, exp_fifo.pop_front());
            end
        end
        if (wr_flag) begin
            if (exp_wr_addr.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got %h@%h expected no write", inst, inst_addr);
            end else begin
                check("inst_addr", inst_addr, exp_wr_addr.pop_front());
                check("inst_data", inst, exp_wr_data.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] word);
        data = word;
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        cyc();
    endtask

    task automatic build_dump();
        for (int i = 0; i < NUM_REGS; i++) exp_fifo.push_back(reg_value(i));
        for (int k = 0; k < LATCH_WORDS; k++) exp_fifo.push_back(latch_value(k));
        for (int a = 0; a < MEM_WORDS; a++) begin
            if (mem_model[a] != 32'd0) begin
                exp_fifo.push_back(mem_model[a]);
                exp_fifo.push_back(32'(a * 4));
            end
        end
        exp_fifo.push_back(WORD_ENDD);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_fifo.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check(name, 32'(exp_fifo.size()), 32'd0);
    endtask

    initial begin
        int n;
        int p0;
        logic [31:0] held;
        rst = 1'b1; data_ready = 1'b0; data = 32'd0; program_end = 1'b0;
        pc = 32'd0; fifo_full = 1'b0;
        for (int k = 0; k < LATCH_WORDS; k++) latches[32*k +: 32] = latch_value(k);
        for (int a = 0; a < MEM_WORDS; a++) mem_model[a] = 32'd0;
        mem_model[2]  = 32'h0000_0005;
        mem_model[63] = 32'h1234_5678;

        cyc(); cyc();
        rst = 1'b0;
        check("rst_halt", halt, 1);
        check("rst_busy", busy, 0);
        check("rst_pc_reset", pc_reset, 0);
        check("rst_stall", stall, 0);
        check("rst_wen", wen, 0);
        check("rst_wr_flag", wr_flag, 0);
        check("rst_inst_addr", inst_addr, 0);
        check("rst_fifo_data", fifo_data, 0);

        // Run request with no program loaded is ignored.
        send(CMD_CONT);
        repeat (4) cyc();
        check("noload_busy", busy, 0);
        check("noload_halt", halt, 1);
        check("noload_pushes", 32'(push_count), 0);

        // Program load terminated by the all-ones word.
        exp_wr_addr = '{32'd0, 32'd4, 32'd8};
        exp_wr_data = '{32'h20010005, 32'h20020007, 32'hFFFFFFFF};
        send(CMD_LOAD);
        check("load_busy", busy, 1);
        send(32'h20010005);
        send(32'h20020007);
        data = 32'hFFFFFFFF; data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        check("load_last_strobe", wr_flag, 1);
        cyc();
        check("load_pc_reset", pc_reset, 1);
        check("load_idle", busy, 0);
        check("load_addr_clear", inst_addr, 0);
        cyc();
        check("load_pc_reset_1cyc", pc_reset, 0);
        check("load_writes_done", 32'(exp_wr_addr.size()), 0);

        // Continuous run ending via program end and drain.
        build_dump();
        check("model_len", 32'(exp_fifo.size()), 32'd48);
        check("model_mem_data", exp_fifo[43], 32'h0000_0005);
        check("model_mem_addr", exp_fifo[44], 32'h0000_0008);
        check("model_last_addr", exp_fifo[46], 32'h0000_00FC);
        check("model_endd", exp_fifo[47], 32'h656e6464);
        p0 = push_count;
        send(CMD_CONT);
        check("run_halt_low", halt, 0);
        check("run_busy", busy, 1);
        repeat (3) cyc();
        check("run_no_stall", stall, 0);
        program_end = 1'b1;
        cyc();
        program_end = 1'b0;
        check("run_stall_on_end", stall, 1);
        check("run_not_halted", halt, 0);
        n = 0;
        while (halt == 1'b0 && n < 20) begin
            cyc();
            n++;
        end
        check("run_drain_len", 32'(n), 32'(DRAIN_CYCLES));
        n = 0;
        while (pc_reset == 1'b0 && n < 400) begin
            cyc();
            n++;
        end
        check("run_dump_pc_reset", pc_reset, 1);
        check("run_dump_empty", 32'(exp_fifo.size()), 0);
        check("run_dump_pushes", 32'(push_count - p0), 32'd48);
        check("run_back_idle", busy, 0);
        check("run_halt_after", halt, 1);
        check("run_stall_clear", stall, 0);
        cyc();
        check("run_pc_reset_1cyc", pc_reset, 0);

        // Breakpoint coinciding with program end; back-pressure mid register dump.
        send(CMD_BP);
        check("bp_wait_addr", busy, 1);
        send(32'h0000_0010);
        check("bp_running", halt, 0);
        build_dump();
        p0 = pcr_count;
        pc = 32'd4; cyc();
        pc = 32'd8; cyc();
        check("bp_not_yet", halt, 0);
        pc = 32'h10; program_end = 1'b1;
        cyc();
        pc = 32'h14; program_end = 1'b0;
        check("bp_halt", halt, 1);
        check("bp_wins_no_stall", stall, 0);
        repeat (8) cyc();
        fifo_full = 1'b1;
        cyc();
        held = fifo_data;
        check("full_no_push", wen, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("full_no_push", wen, 0);
            check("full_data_stable", fifo_data, held);
        end
        fifo_full = 1'b0;
        wait_drain("bp_dump_done", 300);
        repeat (3) cyc();
        check("bp_paused", busy, 1);
        check("bp_paused_halt", halt, 1);
        check("bp_no_pc_reset", 32'(pcr_count - p0), 0);

        // Stall follows program end while paused; single step.
        program_end = 1'b1;
        cyc();
        check("paused_stall", stall, 1);
        program_end = 1'b0;
        cyc();
        check("paused_stall_off", stall, 0);
        build_dump();
        data = CMD_NEXT; data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        check("step_halt_low", halt, 0);
        cyc();
        check("step_halt_back", halt, 1);
        wait_drain("step_dump_done", 300);
        repeat (3) cyc();
        check("step_paused", busy, 1);

        // Cancel from pause.
        data = CMD_CANCEL; data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        check("cancel_pc_reset", pc_reset, 1);
        check("cancel_idle", busy, 0);
        cyc();
        check("cancel_pc_reset_1cyc", pc_reset, 0);

        // Reset in the middle of a dump.
        send(CMD_STEP);
        check("stm_paused", busy, 1);
        build_dump();
        send(CMD_NEXT);
        repeat (20) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rstdump_halt", halt, 1);
        check("rstdump_wen", wen, 0);
        check("rstdump_idle", busy, 0);
        exp_fifo.delete();
        p0 = push_count;
        repeat (5) cyc();
        check("rstdump_no_push", 32'(push_count - p0), 0);
        send(CMD_CONT);
        repeat (3) cyc();
        check("rstdump_not_ready", busy, 0);
        check("rstdump_halt_kept", halt, 1);

        // Load overflow guard: the last instruction slot ends the load.
        for (int i = 0; i < IMEM_WORDS; i++) begin
            exp_wr_addr.push_back(32'(i * 4));
            exp_wr_data.push_back(32'h3000_0000 + 32'(i));
        end
        send(CMD_LOAD);
        for (int i = 0; i < IMEM_WORDS; i++) send(32'h3000_0000 + 32'(i));
        check("ovf_pc_reset", pc_reset, 1);
        check("ovf_idle", busy, 0);
        check("ovf_addr_clear", inst_addr, 0);
        send(32'h3000_0100);
        repeat (2) cyc();
        check("ovf_writes_done", 32'(exp_wr_addr.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
